noc_packetizer: RTL and testbench

- Local-side network interface that injects packets into one fabric node's local receiver port.
- Accepts a packet request (destination, length) plus a payload word stream.
- Emits a head flit, then the payload flits, with the final flit marked tail.
- Allocates one virtual channel per packet, chosen round-robin among free VCs, and holds it for the whole packet.

---
 rtl/noc_packetizer_pkg.sv | 34 +++
 rtl/noc_packetizer_if.sv | 47 ++++
 rtl/noc_packetizer_rr_vc_select.sv | 30 +++
 rtl/noc_packetizer.sv | 130 +++++++++++++
 tb/tb_noc_packetizer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_packetizer_pkg.sv
// Shared NoC definitions: coordinate widths, flit types,
// head-flit field layout and the packetizer state encoding.
package Noc_parameters;

    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;
    localparam int Noc_Len_Width  = 8;

    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VC,
        S_HEAD,
        S_BODY
    } pkt_state_e;

    // Head flit is packed LSB-first: dst_x, dst_y, src_x, src_y, len.
    localparam int HEAD_DST_X_OFS = 0;
    localparam int HEAD_DST_Y_OFS = HEAD_DST_X_OFS + Noc_ID_X_Width;
    localparam int HEAD_SRC_X_OFS = HEAD_DST_Y_OFS + Noc_ID_Y_Width;
    localparam int HEAD_SRC_Y_OFS = HEAD_SRC_X_OFS + Noc_ID_X_Width;
    localparam int HEAD_LEN_OFS   = HEAD_SRC_Y_OFS + Noc_ID_Y_Width;

    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Request, payload and flit channels between the packetizer
// and its upstream source / downstream router port.
interface noc_packetizer_if
    import Noc_parameters::*;
#(
    parameter int DATA_W = 64,
    parameter int VC_NUM = 2,
    parameter int LEN_W  = 8,
    parameter int ID_X_W = Noc_ID_X_Width,
    parameter int ID_Y_W = Noc_ID_Y_Width
);
    localparam int VC_W = vc_w(VC_NUM);

    logic              req_valid;
    logic              req_ready;
    logic [ID_X_W-1:0] req_dst_x;
    logic [ID_Y_W-1:0] req_dst_y;
    logic [LEN_W-1:0]  req_len;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data;
    logic              flit_valid;
    logic              flit_ready;
    logic [1:0]        flit_type;
    logic [VC_W-1:0]   flit_vc;
    logic [DATA_W-1:0] flit_data;
    logic [VC_NUM-1:0] vc_ready;

    modport master (
        input  req_valid, req_dst_x, req_dst_y, req_len,
        output req_ready,
        input  data_valid, data,
        output data_ready,
        output flit_valid, flit_type, flit_vc, flit_data,
        input  flit_ready, vc_ready
    );

    modport slave (
        output req_valid, req_dst_x, req_dst_y, req_len,
        input  req_ready,
        output data_valid, data,
        input  data_ready,
        input  flit_valid, flit_type, flit_vc, flit_data,
        output flit_ready, vc_ready
    );

endinterface

// File: rtl/noc_packetizer_rr_vc_select.sv
// Round-robin search: first set bit of i_vc_ready at or
// after i_rr_ptr, wrapping modulo VC_NUM.
module noc_rr_vc_select
    import Noc_parameters::*;
#(
    parameter int VC_NUM = 2,
    parameter int VC_W   = vc_w(VC_NUM)
) (
    input  logic [VC_NUM-1:0] i_vc_ready,
    input  logic [VC_W-1:0]   i_rr_ptr,
    output logic              o_found,
    output logic [VC_W-1:0]   o_index
);
    logic [2*VC_NUM-1:0] w_dbl;

    assign w_dbl = {i_vc_ready, i_vc_ready} >> i_rr_ptr;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int j = VC_NUM - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                o_found = 1'b1;
                o_index = VC_W'((int'(i_rr_ptr) + j) % VC_NUM);
            end
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Local-port network interface: turns a (dst, len) request plus
// a payload stream into head/body/tail flits on a round-robin VC.
module noc_packetizer
    import Noc_parameters::*;
#(
    parameter int DATA_W = 64,
    parameter int VC_NUM = 2,
    parameter int LEN_W  = 8,
    parameter int ID_X_W = Noc_ID_X_Width,
    parameter int ID_Y_W = Noc_ID_Y_Width
) (
    input  logic              noc_clk,
    input  logic              noc_rst_n,
    input  logic [ID_X_W-1:0] src_x,
    input  logic [ID_Y_W-1:0] src_y,
    noc_packetizer_if.master  bus
);
    localparam int VC_W = vc_w(VC_NUM);

    pkt_state_e        r_state;
    pkt_state_e        w_next;
    logic [ID_X_W-1:0] r_dst_x;
    logic [ID_Y_W-1:0] r_dst_y;
    logic [ID_X_W-1:0] r_src_x;
    logic [ID_Y_W-1:0] r_src_y;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_remain;
    logic [VC_W-1:0]   r_cur_vc;
    logic [VC_W-1:0]   r_rr_ptr;
    logic              w_found;
    logic [VC_W-1:0]   w_sel;
    logic [VC_W-1:0]   w_ptr_nxt;
    logic              w_req_take;
    logic              w_vc_take;
    logic              w_head_xfer;
    logic              w_body_xfer;

    noc_rr_vc_select #(
        .VC_NUM (VC_NUM),
        .VC_W   (VC_W)
    ) u_vc_sel (
        .i_vc_ready (bus.vc_ready),
        .i_rr_ptr   (r_rr_ptr),
        .o_found    (w_found),
        .o_index    (w_sel)
    );

    assign w_ptr_nxt = (w_sel == VC_W'(VC_NUM - 1)) ? '0 : w_sel + 1'b1;
    assign bus.flit_vc = r_cur_vc;

    always_comb begin
        w_next         = r_state;
        w_req_take     = 1'b0;
        w_vc_take      = 1'b0;
        w_head_xfer    = 1'b0;
        w_body_xfer    = 1'b0;
        bus.req_ready  = 1'b0;
        bus.data_ready = 1'b0;
        bus.flit_valid = 1'b0;
        bus.flit_type  = FLIT_BODY;
        bus.flit_data  = '0;
        unique case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_req_take = 1'b1;
                    w_next     = S_WAIT_VC;
                end
            end
            S_WAIT_VC: begin
                if (w_found) begin
                    w_vc_take = 1'b1;
                    w_next    = S_HEAD;
                end
            end
            S_HEAD: begin
                bus.flit_valid = 1'b1;
                bus.flit_type  = (r_len == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
                bus.flit_data  = DATA_W'({r_len, r_src_y, r_src_x,
                                          r_dst_y, r_dst_x});
                if (bus.flit_ready) begin
                    w_head_xfer = 1'b1;
                    w_next      = (r_len == '0) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                bus.flit_valid = bus.data_valid;
                bus.data_ready = bus.flit_ready;
                bus.flit_data  = bus.data;
                bus.flit_type  = (r_remain == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                if (bus.data_valid && bus.flit_ready) begin
                    w_body_xfer = 1'b1;
                    if (r_remain == LEN_W'(1)) w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_state  <= S_IDLE;
            r_dst_x  <= '0;
            r_dst_y  <= '0;
            r_src_x  <= '0;
            r_src_y  <= '0;
            r_len    <= '0;
            r_remain <= '0;
            r_cur_vc <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next;
            if (w_req_take) begin
                r_dst_x <= bus.req_dst_x;
                r_dst_y <= bus.req_dst_y;
                r_src_x <= src_x;
                r_src_y <= src_y;
                r_len   <= bus.req_len;
            end
            if (w_vc_take) begin
                r_cur_vc <= w_sel;
                r_rr_ptr <= w_ptr_nxt;
            end
            // A zero-length packet never enters BODY, so remain stays put.
            if (w_head_xfer && r_len != '0) r_remain <= r_len;
            if (w_body_xfer) r_remain <= r_remain - 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with a queue-based packet model
// and a per-cycle compare process on the flit channel.
module tb_noc_packetizer;
    import Noc_parameters::*;

    localparam int DATA_W = 64;
    localparam int VC_NUM = 2;
    localparam int LEN_W  = 8;
    localparam int XW     = Noc_ID_X_Width;
    localparam int YW     = Noc_ID_Y_Width;

    typedef struct {
        logic [1:0]  t;
        logic [0:0]  vc;
        logic [63:0] d;
    } fl_t;

    logic          noc_clk;
    logic          noc_rst_n;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;

    fl_t         exp_q[$];
    logic [63:0] dq[$];
    logic [1:0]  hd_t[$];
    logic [0:0]  hd_vc[$];
    logic [63:0] hd_d[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_ptr = 0;

    noc_packetizer_if #(
        .DATA_W (DATA_W), .VC_NUM (VC_NUM), .LEN_W (LEN_W),
        .ID_X_W (XW), .ID_Y_W (YW)
    ) bus ();

    noc_packetizer #(
        .DATA_W (DATA_W), .VC_NUM (VC_NUM), .LEN_W (LEN_W),
        .ID_X_W (XW), .ID_Y_W (YW)
    ) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .src_x     (src_x),
        .src_y     (src_y),
        .bus       (bus)
    );

    initial begin
        noc_clk = 1'b0;
        forever #5 noc_clk = ~noc_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] head_word(input int dx, input int dy,
                                              input int len);
        return 64'(dx) << HEAD_DST_X_OFS | 64'(dy) << HEAD_DST_Y_OFS
             | 64'(src_x) << HEAD_SRC_X_OFS | 64'(src_y) << HEAD_SRC_Y_OFS
             | 64'(len) << HEAD_LEN_OFS;
    endfunction

    // Expected flits for one packet; VC picked from the vc_ready value
    // that will be present when the DUT allocates.
    task automatic model_push(input int dx, input int dy, input int len,
                              input logic [1:0] vcr, input logic [63:0] base);
        fl_t f;
        int  v;
        v = -1;
        for (int i = 0; i < VC_NUM; i++) begin
            int k;
            k = (m_ptr + i) % VC_NUM;
            if (v < 0 && ((vcr >> k) & 2'b01) != 2'b00) v = k;
        end
        m_ptr = (v + 1) % VC_NUM;
        f.t  = (len == 0) ? 2'b11 : 2'b01;
        f.vc = 1'(v);
        f.d  = head_word(dx, dy, len);
        exp_q.push_back(f);
        for (int i = 0; i < len; i++) begin
            f.t = (i == len - 1) ? 2'b10 : 2'b00;
            f.d = base + 64'(i);
            exp_q.push_back(f);
            dq.push_back(f.d);
        end
    endtask

    task automatic drive_req(input int dx, input int dy, input int len);
        bit ok;
        ok = 1'b0;
        bus.req_dst_x = XW'(dx);
        bus.req_dst_y = YW'(dy);
        bus.req_len   = LEN_W'(len);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge noc_clk);
            ok = bus.req_ready;
        end
        chk("req_accept", 64'(ok), 64'd1);
        @(posedge noc_clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge noc_clk);
            done = (exp_q.size() == 0) && bus.req_ready;
        end
        chk("wait_idle", 64'(done), 64'd1);
        @(posedge noc_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b0;
        exp_q.delete();
        dq.delete();
        m_ptr = 0;
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
    endtask

    task automatic clr_log();
        hd_t.delete();
        hd_vc.delete();
        hd_d.delete();
    endtask

    function automatic logic [63:0] log_at(input int which, input int i);
        if (which == 0) return (hd_t.size() > i) ? 64'(hd_t[i]) : 'x;
        if (which == 1) return (hd_vc.size() > i) ? 64'(hd_vc[i]) : 'x;
        return (hd_d.size() > i) ? hd_d[i] : 'x;
    endfunction

    // Payload source: presents queued words, pops on each accepted beat.
    initial begin
        bit fire;
        bus.data_valid = 1'b0;
        bus.data       = '0;
        forever begin
            @(negedge noc_clk);
            fire = bus.data_valid && bus.data_ready && noc_rst_n;
            @(posedge noc_clk);
            #1;
            if (fire && dq.size() > 0) void'(dq.pop_front());
            bus.data_valid = (dq.size() > 0);
            bus.data       = bus.data_valid ? dq[0] : '0;
        end
    end

    // Compare process: every cycle out of reset.
    initial begin
        fl_t f;
        forever begin
            @(negedge noc_clk);
            if (noc_rst_n) begin
                if (exp_q.size() > 0 && !exp_q[0].t[0]) begin
                    chk("body_data_ready", 64'(bus.data_ready),
                        64'(bus.flit_ready));
                    chk("body_flit_valid", 64'(bus.flit_valid),
                        64'(bus.data_valid));
                end else begin
                    chk("data_ready_idle", 64'(bus.data_ready), 64'd0);
                end
                if (bus.flit_valid && bus.flit_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_flit", 64'(bus.flit_valid), 64'd0);
                    end else begin
                        f = exp_q.pop_front();
                        chk("flit_type", 64'(bus.flit_type), 64'(f.t));
                        chk("flit_vc", 64'(bus.flit_vc), 64'(f.vc));
                        chk("flit_data", bus.flit_data, f.d);
                        if (f.t[0]) begin
                            hd_t.push_back(bus.flit_type);
                            hd_vc.push_back(bus.flit_vc);
                            hd_d.push_back(bus.flit_data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        noc_rst_n      = 1'b0;
        src_x          = '0;
        src_y          = '0;
        bus.req_valid  = 1'b0;
        bus.req_dst_x  = '0;
        bus.req_dst_y  = '0;
        bus.req_len    = '0;
        bus.flit_ready = 1'b0;
        bus.vc_ready   = '0;
        @(posedge noc_clk);
        #1;
        @(negedge noc_clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("rst_data_ready", 64'(bus.data_ready), 64'd0);
        chk("rst_flit_type", 64'(bus.flit_type), 64'd0);
        chk("rst_flit_vc", 64'(bus.flit_vc), 64'd0);
        chk("rst_flit_data", bus.flit_data, 64'd0);
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;

        // len=3 packet, exact cycle-by-cycle timing
        bus.vc_ready   = 2'b11;
        bus.flit_ready = 1'b1;
        model_push(2, 1, 3, 2'b11, 64'hA);
        drive_req(2, 1, 3);
        @(negedge noc_clk);
        chk("t1_c1_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("t1_c1_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge noc_clk);
        chk("t1_c2_flit_valid", 64'(bus.flit_valid), 64'd1);
        chk("t1_c2_type", 64'(bus.flit_type), 64'd1);
        chk("t1_c2_vc", 64'(bus.flit_vc), 64'd0);
        chk("t1_c2_data", bus.flit_data, 64'h30012);
        @(negedge noc_clk);
        chk("t1_c3_type", 64'(bus.flit_type), 64'd0);
        chk("t1_c3_data", bus.flit_data, 64'hA);
        @(negedge noc_clk);
        chk("t1_c4_data", bus.flit_data, 64'hB);
        @(negedge noc_clk);
        chk("t1_c5_type", 64'(bus.flit_type), 64'd2);
        chk("t1_c5_data", bus.flit_data, 64'hC);
        @(negedge noc_clk);
        chk("t1_c6_req_ready", 64'(bus.req_ready), 64'd1);
        chk("t1_c6_flit_valid", 64'(bus.flit_valid), 64'd0);
        @(posedge noc_clk);
        #1;

        // back-to-back len=1 packets alternate VCs from a fresh pointer
        do_reset();
        clr_log();
        model_push(1, 1, 1, 2'b11, 64'h20);
        drive_req(1, 1, 1);
        model_push(1, 2, 1, 2'b11, 64'h21);
        drive_req(1, 2, 1);
        wait_idle();
        chk("t2_vc_first", log_at(1, 0), 64'd0);
        chk("t2_vc_second", log_at(1, 1), 64'd1);
        chk("t2_type_second", log_at(0, 1), 64'd1);

        // zero-length packet with a non-zero source
        src_x = XW'(5);
        src_y = YW'(6);
        clr_log();
        model_push(3, 2, 0, 2'b11, 64'h0);
        drive_req(3, 2, 0);
        wait_idle();
        chk("t3_type", log_at(0, 0), 64'd3);
        chk("t3_data", log_at(2, 0), 64'h6523);
        chk("t3_vc", log_at(1, 0), 64'd0);

        // no free VC for 5 cycles, then only vc1
        bus.vc_ready = 2'b00;
        model_push(4, 4, 1, 2'b10, 64'h40);
        drive_req(4, 4, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge noc_clk);
            chk("t4_wait_flit_valid", 64'(bus.flit_valid), 64'd0);
        end
        @(posedge noc_clk);
        #1;
        bus.vc_ready = 2'b10;
        @(negedge noc_clk);
        chk("t4_c6_flit_valid", 64'(bus.flit_valid), 64'd0);
        @(negedge noc_clk);
        chk("t4_c7_flit_valid", 64'(bus.flit_valid), 64'd1);
        chk("t4_c7_vc", 64'(bus.flit_vc), 64'd1);
        wait_idle();
        bus.vc_ready = 2'b11;

        // flit_ready stalls during BODY
        model_push(5, 5, 2, 2'b11, 64'h100);
        drive_req(5, 5, 2);
        @(negedge noc_clk);
        @(negedge noc_clk);
        @(posedge noc_clk);
        #1;
        bus.flit_ready = 1'b1;
        @(negedge noc_clk);
        chk("t5_c3_data", bus.flit_data, 64'h100);
        chk("t5_c3_data_ready", 64'(bus.data_ready), 64'd1);
        for (int i = 4; i <= 5; i++) begin
            @(posedge noc_clk);
            #1;
            bus.flit_ready = 1'b0;
            @(negedge noc_clk);
            chk("t5_stall_valid", 64'(bus.flit_valid), 64'd1);
            chk("t5_stall_type", 64'(bus.flit_type), 64'd2);
            chk("t5_stall_data", bus.flit_data, 64'h101);
            chk("t5_stall_data_ready", 64'(bus.data_ready), 64'd0);
        end
        @(posedge noc_clk);
        #1;
        bus.flit_ready = 1'b1;
        @(negedge noc_clk);
        chk("t5_c6_data_ready", 64'(bus.data_ready), 64'd1);
        chk("t5_c6_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge noc_clk);
        chk("t5_c7_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge noc_clk);
        #1;

        // reset mid-BODY; a packet on vc0 leaves the pointer at 1 first
        bus.vc_ready = 2'b01;
        model_push(6, 6, 4, 2'b01, 64'h200);
        drive_req(6, 6, 4);
        @(negedge noc_clk);
        @(negedge noc_clk);
        @(negedge noc_clk);
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b0;
        exp_q.delete();
        dq.delete();
        m_ptr = 0;
        @(posedge noc_clk);
        #1;
        noc_rst_n    = 1'b1;
        bus.vc_ready = 2'b11;
        @(negedge noc_clk);
        chk("t6_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("t6_req_ready", 64'(bus.req_ready), 64'd1);
        chk("t6_data_ready", 64'(bus.data_ready), 64'd0);
        @(posedge noc_clk);
        #1;
        clr_log();
        model_push(7, 7, 1, 2'b11, 64'h300);
        drive_req(7, 7, 1);
        wait_idle();
        chk("t6_vc_after_reset", log_at(1, 0), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
